// File: rtl/tpu_host_ctrl.sv
// Host-side controller for a TPU job: streams A and B operands into their
// buffers, kicks the TPU, waits for it to finish, then streams C rows out.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. ld_ready depends only on the FSM state, never on ld_valid.
// out_valid/out_data/out_last hold steady until out_ready is seen.
module tpu_host_ctrl #(
  parameter int ADDR_W       = 16,
  parameter int KICK_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        cfg_k,
  input  logic [7:0]        cfg_m,
  input  logic [7:0]        cfg_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  output logic              out_last,
  output logic              ctrl_busy,
  output logic              done,
  output logic              err,
  output logic              tpu_in_valid,
  output logic [7:0]        tpu_K,
  output logic [7:0]        tpu_M,
  output logic [7:0]        tpu_N,
  input  logic              tpu_busy,
  output logic              A_wr_en,
  output logic [ADDR_W-1:0] A_index,
  output logic [31:0]       A_data_in,
  output logic              B_wr_en,
  output logic [ADDR_W-1:0] B_index,
  output logic [31:0]       B_data_in,
  output logic              C_wr_en,
  output logic [ADDR_W-1:0] C_index,
  input  logic [127:0]      C_data_out,
  output logic [3:0]        dbg_state_o
);

  typedef enum logic [3:0] {
    IDLE, LOAD_A, LOAD_B, KICK, WAIT_HI, WAIT_LO, RD_ADDR, RD_CAP, OUT, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    k_q, k_d, m_q, m_d, n_q, n_d;
  logic [15:0]   words_q, words_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [7:0]    row_q, row_d;
  logic [15:0]   tmo_q, tmo_d;
  logic          err_q, err_d;
  logic [127:0]  out_data_q, out_data_d;
  logic          last_row;

  assign last_row = (row_q == k_q - 8'd1);

  // State and datapath registers; reset drops any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      m_q        <= '0;
      n_q        <= '0;
      words_q    <= '0;
      cnt_q      <= '0;
      row_q      <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      m_q        <= m_d;
      n_q        <= n_d;
      words_q    <= words_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      out_data_q <= out_data_d;
    end
  end

  // Next-state logic: sequencing of load, kick, wait and readout phases.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    m_d        = m_q;
    n_d        = n_q;
    words_d    = words_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = cfg_k;
          m_d     = cfg_m;
          n_d     = cfg_n;
          words_d = 16'(cfg_k) * 16'(cfg_m);
          cnt_d   = '0;
          err_d   = 1'b0;
          // An empty job has nothing to load or compute.
          state_d = (cfg_k == 8'd0 || cfg_m == 8'd0) ? DONE : LOAD_A;
        end
      end
      LOAD_A, LOAD_B: begin
        if (ld_valid) begin
          if (cnt_q == words_q - 16'd1) begin
            cnt_d   = '0;
            state_d = (state_q == LOAD_A) ? LOAD_B : KICK;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      KICK: begin
        tmo_d   = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (tpu_busy) begin
          state_d = WAIT_LO;
        end else if (tmo_q == 16'(KICK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      WAIT_LO: begin
        if (!tpu_busy) begin
          row_d   = '0;
          state_d = RD_ADDR;
        end
      end
      RD_ADDR: state_d = RD_CAP;
      RD_CAP: begin
        // C buffer read data is valid the cycle after the address.
        out_data_d = C_data_out;
        state_d    = OUT;
      end
      OUT: begin
        if (out_ready) begin
          if (last_row) begin
            state_d = DONE;
          end else begin
            row_d   = row_q + 8'd1;
            state_d = RD_ADDR;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; buffer writes only on accepted beats.
  always_comb begin
    ld_ready     = (state_q == LOAD_A) || (state_q == LOAD_B);
    A_wr_en      = (state_q == LOAD_A) && ld_valid;
    B_wr_en      = (state_q == LOAD_B) && ld_valid;
    A_index      = A_wr_en ? ADDR_W'(cnt_q) : '0;
    B_index      = B_wr_en ? ADDR_W'(cnt_q) : '0;
    A_data_in    = A_wr_en ? ld_data : '0;
    B_data_in    = B_wr_en ? ld_data : '0;
    C_wr_en      = 1'b0;
    C_index      = (state_q == RD_ADDR) ? ADDR_W'(row_q) : '0;
    out_valid    = (state_q == OUT);
    out_last     = (state_q == OUT) && last_row;
    out_data     = out_data_q;
    ctrl_busy    = (state_q != IDLE);
    done         = (state_q == DONE);
    err          = err_q;
    tpu_in_valid = (state_q == KICK);
    tpu_K        = k_q;
    tpu_M        = m_q;
    tpu_N        = n_q;
    dbg_state_o  = state_q;
  end

endmodule
